// File: rtl/RS5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : RS5_pkg
// Purpose  : Shared TMR recovery types, FSM state encodings and lane indices.
// Revision : 1.0 - initial release
// ============================================================================
package RS5_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    RESYNC   = 2'd1,
    DEGRADED = 2'd2,
    FATAL    = 2'd3
  } tmrState_e;

  // Raw encodings mirror tmrState_e for code that carries the state as plain logic.
  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_RESYNC   = 2'd1;
  localparam logic [1:0] ST_DEGRADED = 2'd2;
  localparam logic [1:0] ST_FATAL    = 2'd3;

  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  localparam int NUM_LANES = 3;

endpackage
`default_nettype wire

// File: rtl/tmr_lane_counter.sv
`default_nettype none
// ============================================================================
// Module   : tmr_lane_counter
// Purpose  : Per-lane consecutive and total mismatch counters with
//            saturation and freeze-while-disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_lane_counter
  import RS5_pkg::*;
#(
  parameter int unsigned THRESHOLD   = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  input  logic                   mismatch_i,
  input  logic                   disabled_i,
  output logic                   thresh_hit_o,
  output logic [COUNT_WIDTH-1:0] total_cnt_o
);

  localparam int unsigned      CONS_W   = $clog2(THRESHOLD + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(THRESHOLD);

  logic [CONS_W-1:0]      cons_q, cons_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic                   sample;

  always_comb begin
    sample  = valid_i & ~disabled_i;
    cons_d  = cons_q;
    total_d = total_q;
    if (sample) begin
      if (mismatch_i) begin
        if (cons_q != CONS_MAX) cons_d = cons_q + CONS_W'(1);
        if (total_q != '1)      total_d = total_q + COUNT_WIDTH'(1);
      end else begin
        cons_d = '0;
      end
    end
    // A sample that lands on an already-saturated counter still counts as a hit.
    thresh_hit_o = sample & mismatch_i & (cons_d == CONS_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cons_q  <= '0;
      total_q <= '0;
    end else begin
      cons_q  <= cons_d;
      total_q <= total_d;
    end
  end

  assign total_cnt_o = total_q;

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tmr_recovery_ctrl
// Purpose  : TMR lane-fault tracking and recovery FSM (resync, degrade, fatal).
// Revision : 1.0 - initial release
// ============================================================================
module tmr_recovery_ctrl
  import RS5_pkg::*;
#(
  parameter int unsigned THRESHOLD   = 4,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  input  logic                   mismatch_a_i,
  input  logic                   mismatch_b_i,
  input  logic                   mismatch_c_i,
  input  logic                   no_majority_i,
  input  logic                   recover_ack_i,
  output logic                   recover_req_o,
  output logic [2:0]             lane_disable_o,
  output logic [1:0]             primary_lane_o,
  output logic [COUNT_WIDTH-1:0] fault_cnt_a_o,
  output logic [COUNT_WIDTH-1:0] fault_cnt_b_o,
  output logic [COUNT_WIDTH-1:0] fault_cnt_c_o,
  output logic                   fatal_o,
  output logic [1:0]             state_o
);

  logic [1:0]             state_q, state_d;
  logic                   recover_req_q, recover_req_d;
  logic                   fatal_q, fatal_d;
  logic [2:0]             lane_disable_q, lane_disable_d;
  logic [1:0]             primary_lane_q, primary_lane_d;

  logic [2:0]             mismatch_vec;
  logic [2:0]             enabled_mis;
  logic [2:0]             thresh_hit;
  logic                   multi_mis;
  logic [COUNT_WIDTH-1:0] total_cnt [NUM_LANES];

  assign mismatch_vec = {mismatch_c_i, mismatch_b_i, mismatch_a_i};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    tmr_lane_counter #(
      .THRESHOLD   (THRESHOLD),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_lane_counter (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid_i      (valid_i),
      .mismatch_i   (mismatch_vec[gi]),
      .disabled_i   (lane_disable_q[gi]),
      .thresh_hit_o (thresh_hit[gi]),
      .total_cnt_o  (total_cnt[gi])
    );
  end

  always_comb begin
    enabled_mis = mismatch_vec & ~lane_disable_q;
    multi_mis   = (enabled_mis[0] & enabled_mis[1]) |
                  (enabled_mis[0] & enabled_mis[2]) |
                  (enabled_mis[1] & enabled_mis[2]);

    state_d        = state_q;
    recover_req_d  = recover_req_q;
    fatal_d        = fatal_q;
    lane_disable_d = lane_disable_q;

    case (state_q)
      ST_NORMAL: begin
        recover_req_d = 1'b0;
        if (valid_i) begin
          if (no_majority_i || multi_mis) begin
            state_d = ST_FATAL;
            fatal_d = 1'b1;
          end else if (|thresh_hit) begin
            // Only one lane can be hit here; multi-lane mismatches went fatal above.
            if (lane_disable_q == 3'b000) lane_disable_d = thresh_hit;
            recover_req_d = 1'b1;
            state_d       = ST_RESYNC;
          end else if (|enabled_mis) begin
            recover_req_d = 1'b1;
            state_d       = ST_RESYNC;
          end
        end
      end
      ST_RESYNC: begin
        recover_req_d = 1'b1;
        if (recover_ack_i) begin
          recover_req_d = 1'b0;
          state_d       = (|lane_disable_q) ? ST_DEGRADED : ST_NORMAL;
        end
      end
      ST_DEGRADED: begin
        recover_req_d = 1'b0;
        if (valid_i && (no_majority_i || (|enabled_mis))) begin
          state_d = ST_FATAL;
          fatal_d = 1'b1;
        end
      end
      ST_FATAL: begin
        recover_req_d = 1'b0;
        fatal_d       = 1'b1;
      end
      default: begin
        state_d       = ST_NORMAL;
        recover_req_d = 1'b0;
      end
    endcase

    primary_lane_d = lane_disable_d[LANE_A] ? LANE_B : LANE_A;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_NORMAL;
      recover_req_q  <= 1'b0;
      fatal_q        <= 1'b0;
      lane_disable_q <= 3'b000;
      primary_lane_q <= LANE_A;
    end else begin
      state_q        <= state_d;
      recover_req_q  <= recover_req_d;
      fatal_q        <= fatal_d;
      lane_disable_q <= lane_disable_d;
      primary_lane_q <= primary_lane_d;
    end
  end

  assign state_o        = state_q;
  assign recover_req_o  = recover_req_q;
  assign fatal_o        = fatal_q;
  assign lane_disable_o = lane_disable_q;
  assign primary_lane_o = primary_lane_q;
  assign fault_cnt_a_o  = total_cnt[LANE_A];
  assign fault_cnt_b_o  = total_cnt[LANE_B];
  assign fault_cnt_c_o  = total_cnt[LANE_C];

endmodule
`default_nettype wire

// File: tb/tb_tmr_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmr_recovery_ctrl
// Purpose  : Directed, model-checked bench for tmr_recovery_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmr_recovery_ctrl;

  localparam int TH   = 4;
  localparam int CW   = 8;
  localparam int TMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_i, mismatch_a_i, mismatch_b_i, mismatch_c_i;
  logic          no_majority_i, recover_ack_i;
  logic          recover_req_o, fatal_o;
  logic [2:0]    lane_disable_o;
  logic [1:0]    primary_lane_o, state_o;
  logic [CW-1:0] fault_cnt_a_o, fault_cnt_b_o, fault_cnt_c_o;

  int checks   = 0;
  int failures = 0;

  tmr_recovery_ctrl #(.THRESHOLD(TH), .COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_i        (valid_i),
    .mismatch_a_i   (mismatch_a_i),
    .mismatch_b_i   (mismatch_b_i),
    .mismatch_c_i   (mismatch_c_i),
    .no_majority_i  (no_majority_i),
    .recover_ack_i  (recover_ack_i),
    .recover_req_o  (recover_req_o),
    .lane_disable_o (lane_disable_o),
    .primary_lane_o (primary_lane_o),
    .fault_cnt_a_o  (fault_cnt_a_o),
    .fault_cnt_b_o  (fault_cnt_b_o),
    .fault_cnt_c_o  (fault_cnt_c_o),
    .fatal_o        (fatal_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=NORMAL 1=RESYNC 2=DEGRADED 3=FATAL.
  int m_state = 0;
  int m_req   = 0;
  int m_fatal = 0;
  int m_dis[3]  = '{0, 0, 0};
  int m_cons[3] = '{0, 0, 0};
  int m_tot[3]  = '{0, 0, 0};

  function automatic int m_dis_mask();
    return m_dis[0] + 2 * m_dis[1] + 4 * m_dis[2];
  endfunction

  function automatic int m_primary();
    if (m_dis_mask() == 0) return 0;
    for (int i = 0; i < 3; i++) if (m_dis[i] == 0) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_req = 0; m_fatal = 0;
    for (int i = 0; i < 3; i++) begin
      m_dis[i] = 0; m_cons[i] = 0; m_tot[i] = 0;
    end
  endtask

  task automatic model_step();
    int mis[3];
    int n_en;
    int hit_lane;
    mis[0] = int'(mismatch_a_i); mis[1] = int'(mismatch_b_i); mis[2] = int'(mismatch_c_i);
    n_en = 0;
    hit_lane = -1;
    for (int i = 0; i < 3; i++) begin
      if (valid_i && m_dis[i] == 0) begin
        if (mis[i] != 0) begin
          n_en++;
          m_cons[i] = (m_cons[i] < TH) ? m_cons[i] + 1 : TH;
          if (m_tot[i] < TMAX) m_tot[i]++;
          if (m_cons[i] == TH) hit_lane = i;
        end else begin
          m_cons[i] = 0;
        end
      end
    end
    case (m_state)
      0: if (valid_i) begin
           if (no_majority_i || n_en >= 2) begin
             m_state = 3; m_fatal = 1;
           end else if (hit_lane >= 0) begin
             m_dis[hit_lane] = 1; m_req = 1; m_state = 1;
           end else if (n_en == 1) begin
             m_req = 1; m_state = 1;
           end
         end
      1: if (recover_ack_i) begin
           m_req = 0;
           m_state = (m_dis_mask() != 0) ? 2 : 0;
         end
      2: if (valid_i && (no_majority_i || n_en > 0)) begin
           m_state = 3; m_fatal = 1;
         end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Continuous compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("state",        state_o,        m_state);
      check("recover_req",  recover_req_o,  m_req);
      check("fatal",        fatal_o,        m_fatal);
      check("lane_disable", lane_disable_o, m_dis_mask());
      check("primary_lane", primary_lane_o, m_primary());
      check("fault_cnt_a",  fault_cnt_a_o,  m_tot[0]);
      check("fault_cnt_b",  fault_cnt_b_o,  m_tot[1]);
      check("fault_cnt_c",  fault_cnt_c_o,  m_tot[2]);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic cycle(input bit v, input bit a, input bit b, input bit c,
                       input bit nm, input bit ack);
    valid_i = v; mismatch_a_i = a; mismatch_b_i = b; mismatch_c_i = c;
    no_majority_i = nm; recover_ack_i = ack;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    valid_i = 0; mismatch_a_i = 0; mismatch_b_i = 0; mismatch_c_i = 0;
    no_majority_i = 0; recover_ack_i = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_req",   recover_req_o, 0);
    check("rst_fatal", fatal_o, 0);
    check("rst_dis",   lane_disable_o, 0);
    check("rst_cnt_a", fault_cnt_a_o, 0);
    reset_n = 1'b1;
    idle();

    // Single mismatch on lane b, then ack back to NORMAL.
    cycle(1, 0, 1, 0, 0, 0);
    check("single_req", recover_req_o, 1);
    check("single_state", state_o, 1);
    idle();
    check("single_req_held", recover_req_o, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("single_ack_state", state_o, 0);
    check("single_ack_req", recover_req_o, 0);
    check("single_cnt_b", fault_cnt_b_o, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check("stray_ack_state", state_o, 0);
    cycle(0, 1, 1, 1, 1, 0);
    check("gated_state", state_o, 0);
    check("gated_cnt_a", fault_cnt_a_o, 0);
    check("gated_cnt_b", fault_cnt_b_o, 1);
    cycle(1, 0, 0, 0, 0, 0);

    // Four consecutive lane-c mismatches reach the threshold.
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0, 1, 0, 0);
      check("thr_req", recover_req_o, 1);
      if (k == 3) check("thr_dis_before", lane_disable_o, 3'b000);
      if (k == 4) check("thr_dis", lane_disable_o, 3'b100);
      cycle(0, 0, 0, 0, 0, 1);
    end
    check("thr_state", state_o, 2);
    check("thr_primary", primary_lane_o, 0);
    check("thr_cnt_c", fault_cnt_c_o, 4);
    cycle(1, 0, 0, 1, 0, 0);
    check("deg_ignore_c_state", state_o, 2);
    check("deg_ignore_c_cnt", fault_cnt_c_o, 4);

    // Enabled-lane mismatch in DEGRADED is fatal; only reset clears it.
    cycle(1, 1, 0, 0, 0, 0);
    check("deg_fatal", fatal_o, 1);
    check("deg_fatal_state", state_o, 3);
    check("deg_fatal_req", recover_req_o, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("fatal_sticky", state_o, 3);
    pulse_reset();
    check("post_rst_fatal", fatal_o, 0);
    check("post_rst_state", state_o, 0);
    check("post_rst_dis", lane_disable_o, 0);
    idle();

    // Lane-a threshold moves the primary lane to b.
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
    end
    check("thr_a_dis", lane_disable_o, 3'b001);
    check("thr_a_primary", primary_lane_o, 1);
    check("thr_a_state", state_o, 2);
    pulse_reset();
    idle();

    // Two simultaneous mismatches go straight to FATAL.
    cycle(1, 1, 1, 0, 0, 0);
    check("dual_state", state_o, 3);
    check("dual_fatal", fatal_o, 1);
    check("dual_dis", lane_disable_o, 0);

    // Total counter saturates at all-ones.
    for (int k = 0; k < 300; k++) cycle(1, 1, 0, 0, 0, 0);
    check("sat_cnt_a", fault_cnt_a_o, 255);
    check("sat_cnt_b", fault_cnt_b_o, 1);
    pulse_reset();
    idle();

    cycle(1, 0, 0, 0, 1, 0);
    check("nomaj_state", state_o, 3);
    pulse_reset();
    idle();

    // Reset mid-RESYNC drops the request without a clock edge.
    cycle(1, 1, 0, 0, 0, 0);
    check("mid_req", recover_req_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_req", recover_req_o, 0);
    check("async_state", state_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    check("resume_state", state_o, 0);
    check("resume_req", recover_req_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
